// File: rtl/fog_ctrl_pkg.sv
// Shared types and constants for the FOG phase-ramp timebase/mode controller.
package fog_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_OPEN   = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;
    localparam state_t ST_CLOSED = 2'd3;

    localparam logic [1:0] FB_OPEN   = 2'd0;
    localparam logic [1:0] FB_CLOSED = 2'd1;
    localparam logic [1:0] FB_STEP   = 2'd2;

    localparam logic [3:0]        GAIN_INIT_DFLT = 4'd5;
    localparam logic [DATA_W-1:0] HP_MIN_DFLT    = 32'd4;

    localparam logic signed [DATA_W-1:0] AMP_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [DATA_W-1:0] AMP_MIN = 32'sh8000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] hp;
        logic [DATA_W-1:0] rate_dly;
        logic [DATA_W-1:0] amp;
        logic [3:0]        gain;
        logic [1:0]        fb;
    } cfg_t;

    // Request code 3 is reserved and behaves as open-loop.
    function automatic logic [1:0] fb_map(input logic [1:0] req);
        return (req == 2'd3) ? FB_OPEN : req;
    endfunction

endpackage

// File: rtl/phase_ramp_timebase.sv
// Half-period counter, polarity, clamped rate delay and registered trigger pulses.
module phase_ramp_timebase
    import fog_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] HP_MIN = HP_MIN_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_active,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_half_period,
    input  logic [DATA_W-1:0] i_rate_dly,
    output logic              o_boundary,
    output logic              o_pol_nxt,
    output logic              o_mod_trig,
    output logic              o_rate_trig,
    output logic              o_ramp_trig
);

    logic [DATA_W-1:0] hp;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] cnt_nxt;
    logic              pol;
    logic              wrap;

    // Triggers are registered from the next count, so they line up with cnt itself.
    always_comb begin
        hp = (i_half_period < HP_MIN) ? HP_MIN : i_half_period;
        if (i_rate_dly == '0)
            rd = 32'd1;
        else if (i_rate_dly > hp - 32'd2)
            rd = hp - 32'd2;
        else
            rd = i_rate_dly;
        wrap       = (cnt == hp - 32'd1);
        o_boundary = i_active && wrap && pol;
        if (!i_active || !i_run) begin
            cnt_nxt   = '0;
            o_pol_nxt = 1'b0;
        end else if (wrap) begin
            cnt_nxt   = '0;
            o_pol_nxt = ~pol;
        end else begin
            cnt_nxt   = cnt + 32'd1;
            o_pol_nxt = pol;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt         <= '0;
            pol         <= 1'b0;
            o_mod_trig  <= 1'b0;
            o_rate_trig <= 1'b0;
            o_ramp_trig <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            pol         <= o_pol_nxt;
            o_mod_trig  <= i_run && (cnt_nxt == '0);
            o_rate_trig <= i_run && (cnt_nxt == rd);
            o_ramp_trig <= i_run && (cnt_nxt == rd + 32'd1);
        end
    end

endmodule

// File: rtl/phase_ramp_sched.sv
// FOG phase-ramp scheduler: shadowed config committed on period boundaries and
// the open/settle/closed feedback mode sequencer.
module phase_ramp_sched
    import fog_ctrl_pkg::*;
#(
    parameter int unsigned       SETTLE_PERIODS = 16,
    parameter logic [3:0]        GAIN_INIT      = GAIN_INIT_DFLT,
    parameter logic [DATA_W-1:0] HP_MIN         = HP_MIN_DFLT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [DATA_W-1:0]        i_half_period,
    input  logic [DATA_W-1:0]        i_rate_dly,
    input  logic signed [DATA_W-1:0] i_mod_amp,
    input  logic [1:0]               i_fb_req,
    input  logic [3:0]               i_gain_req,
    output logic                     o_mod_trig,
    output logic                     o_rate_trig,
    output logic                     o_ramp_trig,
    output logic signed [DATA_W-1:0] o_mod,
    output logic [DATA_W-1:0]        o_fb_on,
    output logic [DATA_W-1:0]        o_gain_sel,
    output logic [1:0]               o_state,
    output logic                     o_cfg_ack
);

    localparam int              SC_W        = $clog2(SETTLE_PERIODS + 1);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_PERIODS - 1);

    function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] a);
        return (a == AMP_MIN) ? AMP_MAX : -a;
    endfunction

    cfg_t            shadow_p0;
    cfg_t            cfg_p1;
    cfg_t            cfg_nxt;
    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] settle_cnt;
    logic [SC_W-1:0] settle_nxt;
    logic            commit;
    logic            boundary;
    logic            pol_nxt;

    phase_ramp_timebase #(
        .HP_MIN (HP_MIN)
    ) u_timebase (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_active      (state != ST_IDLE),
        .i_run         (state_nxt != ST_IDLE),
        .i_half_period (cfg_p1.hp),
        .i_rate_dly    (cfg_p1.rate_dly),
        .o_boundary    (boundary),
        .o_pol_nxt     (pol_nxt),
        .o_mod_trig    (o_mod_trig),
        .o_rate_trig   (o_rate_trig),
        .o_ramp_trig   (o_ramp_trig)
    );

    // p0 -> p1: shadow set becomes the committed set on IDLE exit or a period boundary
    always_comb begin
        commit     = i_enable && ((state == ST_IDLE) || boundary);
        cfg_nxt    = commit ? shadow_p0 : cfg_p1;
        state_nxt  = state;
        settle_nxt = settle_cnt;
        if (!i_enable) begin
            state_nxt  = ST_IDLE;
            settle_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_OPEN;
                ST_OPEN: begin
                    if (boundary && cfg_nxt.fb == FB_CLOSED) begin
                        state_nxt  = ST_SETTLE;
                        settle_nxt = '0;
                    end else if (boundary && cfg_nxt.fb == FB_STEP) begin
                        state_nxt = ST_CLOSED;
                    end
                end
                ST_SETTLE: begin
                    if (boundary) begin
                        settle_nxt = '0;
                        if (cfg_nxt.fb == FB_OPEN)
                            state_nxt = ST_OPEN;
                        else if (cfg_nxt.fb == FB_STEP || settle_cnt == SETTLE_LAST)
                            state_nxt = ST_CLOSED;
                        else
                            settle_nxt = settle_cnt + SC_W'(1);
                    end
                end
                default: begin
                    if (boundary && cfg_nxt.fb == FB_OPEN)
                        state_nxt = ST_OPEN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        shadow_p0.hp       <= i_half_period;
        shadow_p0.rate_dly <= i_rate_dly;
        shadow_p0.amp      <= i_mod_amp;
        shadow_p0.gain     <= i_gain_req;
        shadow_p0.fb       <= fb_map(i_fb_req);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            settle_cnt      <= '0;
            cfg_p1.hp       <= '0;
            cfg_p1.rate_dly <= '0;
            cfg_p1.amp      <= '0;
            cfg_p1.gain     <= GAIN_INIT;
            cfg_p1.fb       <= FB_OPEN;
            o_mod           <= '0;
            o_fb_on         <= '0;
            o_cfg_ack       <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            cfg_p1     <= cfg_nxt;
            o_cfg_ack  <= commit && (shadow_p0 != cfg_p1);
            if (state_nxt == ST_IDLE)
                o_mod <= '0;
            else
                o_mod <= pol_nxt ? neg_sat($signed(cfg_nxt.amp)) : $signed(cfg_nxt.amp);
            o_fb_on <= (state_nxt == ST_CLOSED) ? {{(DATA_W-2){1'b0}}, cfg_nxt.fb} : '0;
        end
    end

    assign o_gain_sel = {{(DATA_W-4){1'b0}}, cfg_p1.gain};
    assign o_state    = state;

endmodule
